// File: rtl/qqspi_arbiter.sv
// qqspi_arbiter: two-master arbiter and flash/PSRAM decoder in front of the qqspi controller.
// Define QQSPI_ARB_RR_EN for round-robin arbitration; otherwise M0 has fixed priority.
module qqspi_arbiter #(
    parameter logic [31:0] FLASH_BASE = 32'h2000_0000,
    parameter logic [31:0] PSRAM_BASE = 32'h8000_0000,
    parameter logic        FLASH_QUAD = 1'b0,
    parameter logic        PSRAM_QUAD = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [22:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        flash_valid,
    output logic        psram_valid,
    output logic        psram_spiflash,
    output logic        quad_mode
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;
    state_t      state, state_n;
    logic        grant, grant_n;
    logic        mem_valid_n, flash_valid_n, psram_valid_n, psram_spiflash_n, quad_mode_n;
    logic [22:0] mem_addr_n;
    logic [31:0] mem_wdata_n, m0_rdata_n, m1_rdata_n;
    logic [3:0]  mem_wstrb_n;
    logic        m0_ready_n, m1_ready_n, m0_err_n, m1_err_n;
    logic        pend0, pend1, pick, start, psram_hit, flash_hit, mapped;
    logic [31:0] sel_addr, sel_wdata;
    logic [3:0]  sel_wstrb;
    logic        unused_addr_lsbs;

    // A master whose ready is high this cycle is finishing, not requesting again.
    assign pend0 = m0_valid & ~m0_ready;
    assign pend1 = m1_valid & ~m1_ready;
    assign start = (state == IDLE) & (pend0 | pend1) & ~mem_ready;

`ifdef QQSPI_ARB_RR_EN
    logic last;
    assign pick = (pend0 & pend1) ? ~last : pend1;
    always_ff @(posedge clk or posedge reset)
        if (reset) last <= 1'b1;
        else if (start) last <= pick;
`else
    assign pick = ~pend0;
`endif

    assign sel_addr         = pick ? m1_addr : m0_addr;
    assign sel_wdata        = pick ? m1_wdata : m0_wdata;
    assign sel_wstrb        = pick ? m1_wstrb : m0_wstrb;
    assign psram_hit        = sel_addr[31:25] == PSRAM_BASE[31:25];
    assign flash_hit        = sel_addr[31:25] == FLASH_BASE[31:25];
    assign mapped           = psram_hit | (flash_hit & (sel_wstrb == 4'd0));
    assign unused_addr_lsbs = ^sel_addr[1:0];

    always_comb begin
        state_n          = state;
        grant_n          = grant;
        mem_valid_n      = mem_valid;
        mem_addr_n       = mem_addr;
        mem_wdata_n      = mem_wdata;
        mem_wstrb_n      = mem_wstrb;
        flash_valid_n    = flash_valid;
        psram_valid_n    = psram_valid;
        psram_spiflash_n = psram_spiflash;
        quad_mode_n      = quad_mode;
        m0_rdata_n       = m0_rdata;
        m1_rdata_n       = m1_rdata;
        m0_ready_n       = 1'b0;
        m1_ready_n       = 1'b0;
        m0_err_n         = 1'b0;
        m1_err_n         = 1'b0;
        case (state)
            IDLE: if (start) begin
                grant_n = pick;
                state_n = mapped ? ISSUE : RESP;
                if (mapped) begin
                    mem_valid_n      = 1'b1;
                    mem_addr_n       = sel_addr[24:2];
                    mem_wdata_n      = sel_wdata;
                    mem_wstrb_n      = sel_wstrb;
                    flash_valid_n    = ~psram_hit;
                    psram_valid_n    = psram_hit;
                    psram_spiflash_n = psram_hit;
                    quad_mode_n      = psram_hit ? PSRAM_QUAD : FLASH_QUAD;
                end
            end
            ISSUE: if (mem_ready) begin
                state_n     = DRAIN;
                mem_valid_n = 1'b0;
                m0_ready_n  = ~grant;
                m1_ready_n  = grant;
                m0_rdata_n  = grant ? m0_rdata : mem_rdata;
                m1_rdata_n  = grant ? mem_rdata : m1_rdata;
            end
            // Hold the region strobes until qqspi has released ready.
            DRAIN: if (!mem_ready) begin
                state_n       = IDLE;
                flash_valid_n = 1'b0;
                psram_valid_n = 1'b0;
            end
            RESP: begin
                state_n    = IDLE;
                m0_ready_n = ~grant;
                m0_err_n   = ~grant;
                m1_ready_n = grant;
                m1_err_n   = grant;
                m0_rdata_n = grant ? m0_rdata : 32'd0;
                m1_rdata_n = grant ? 32'd0 : m1_rdata;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            grant          <= 1'b0;
            mem_valid      <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_wstrb      <= '0;
            flash_valid    <= 1'b0;
            psram_valid    <= 1'b0;
            psram_spiflash <= 1'b0;
            quad_mode      <= 1'b0;
            m0_rdata       <= '0;
            m1_rdata       <= '0;
            m0_ready       <= 1'b0;
            m1_ready       <= 1'b0;
            m0_err         <= 1'b0;
            m1_err         <= 1'b0;
        end else begin
            state          <= state_n;
            grant          <= grant_n;
            mem_valid      <= mem_valid_n;
            mem_addr       <= mem_addr_n;
            mem_wdata      <= mem_wdata_n;
            mem_wstrb      <= mem_wstrb_n;
            flash_valid    <= flash_valid_n;
            psram_valid    <= psram_valid_n;
            psram_spiflash <= psram_spiflash_n;
            quad_mode      <= quad_mode_n;
            m0_rdata       <= m0_rdata_n;
            m1_rdata       <= m1_rdata_n;
            m0_ready       <= m0_ready_n;
            m1_ready       <= m1_ready_n;
            m0_err         <= m0_err_n;
            m1_err         <= m1_err_n;
        end
    end
endmodule

// File: tb/tb_qqspi_arbiter.sv
// tb_qqspi_arbiter: directed and randomized checks of qqspi_arbiter against a transaction-level model.
module tb_qqspi_arbiter;
    logic        clk = 1'b0, reset = 1'b1;
    logic        m0_valid = 1'b0, m1_valid = 1'b0, mem_ready = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0, mem_rdata = '0;
    logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
    logic        m0_ready, m1_ready, m0_err, m1_err, mem_valid;
    logic        flash_valid, psram_valid, psram_spiflash, quad_mode;
    logic [31:0] m0_rdata, m1_rdata, mem_wdata;
    logic [22:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] exp_rd [2];
    int          vectors = 0, miscompares = 0;

    qqspi_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .flash_valid(flash_valid), .psram_valid(psram_valid),
        .psram_spiflash(psram_spiflash), .quad_mode(quad_mode)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input logic m);
        return m ? m1_ready : m0_ready;
    endfunction
    function automatic logic err(input logic m);
        return m ? m1_err : m0_err;
    endfunction
    function automatic logic [31:0] rd(input logic m);
        return m ? m1_rdata : m0_rdata;
    endfunction
    function automatic logic all_zero();
        return {m0_ready, m1_ready, m0_err, m1_err, mem_valid, flash_valid, psram_valid,
                psram_spiflash, quad_mode, mem_addr, mem_wdata, mem_wstrb, m0_rdata, m1_rdata} === '0;
    endfunction

    task automatic drive(input logic m, input logic v, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws);
        if (m) begin m1_valid = v; m1_addr = a; m1_wdata = wd; m1_wstrb = ws; end
        else begin m0_valid = v; m0_addr = a; m0_wdata = wd; m0_wstrb = ws; end
    endtask

    task automatic set_valid(input logic m, input logic v);
        if (m) m1_valid = v; else m0_valid = v;
    endtask

    // One isolated transaction; called at a falling edge with the arbiter idle.
    task automatic single(input logic m, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input int lat, input logic [31:0] mrd);
        logic ps, fl, bad;
        ps  = a[31:25] == 7'h40;
        fl  = a[31:25] == 7'h10;
        bad = !(ps || (fl && ws == 4'd0));
        drive(m, 1'b1, a, wd, ws);
        @(negedge clk);
        if (bad) begin
            chk("err_no_issue", 64'(mem_valid), 64'(0));
            @(negedge clk);
            exp_rd[m] = 32'd0;
            chk("err_resp", 64'({rdy(m), err(m), rdy(!m), mem_valid}), 64'(4'b1100));
            chk("err_rdata", 64'(rd(m)), 64'(exp_rd[m]));
            set_valid(m, 1'b0);
            @(negedge clk);
            chk("err_release", 64'({rdy(m), rdy(!m), err(m)}), 64'(0));
        end else begin
            chk("issue_addr", 64'(mem_addr), 64'(a[24:2]));
            chk("issue_cfg", 64'({mem_valid, flash_valid, psram_valid, psram_spiflash, quad_mode, mem_wstrb}),
                64'({1'b1, ps ? 4'b0111 : 4'b1000, ws}));
            chk("issue_wdata", 64'(mem_wdata), 64'(wd));
            repeat (lat - 1) @(negedge clk);
            chk("no_early_ready", 64'({m0_ready, m1_ready, mem_valid}), 64'(3'b001));
            mem_ready = 1'b1;
            mem_rdata = mrd;
            @(negedge clk);
            exp_rd[m] = mrd;
            chk("ready_pulse", 64'({rdy(m), err(m), rdy(!m), mem_valid}), 64'(4'b1000));
            chk("rdata", 64'(rd(m)), 64'(mrd));
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            set_valid(m, 1'b0);
            @(negedge clk);
            chk("drain_done", 64'({rdy(m), flash_valid, psram_valid}), 64'(0));
        end
        chk("other_rdata_hold", 64'(rd(!m)), 64'(exp_rd[!m]));
    endtask

    initial begin
        int          exp_q[$], got[$];
        int          n[2];
        int          r0, r1, w, dly, cyc;
        logic        lst, m;
        logic [6:0]  u;
        logic [31:0] a, last_rd;
        logic [3:0]  ws;
        exp_rd = '{32'd0, 32'd0};
        repeat (2) @(negedge clk);
        chk("reset_outputs", 64'(all_zero()), 64'(1));
        reset = 1'b0;
        @(negedge clk);

        single(1'b0, 32'h8000_0010, 32'h0, 4'd0, 5, 32'hDEADBEEF);
        chk("tp1_mem_addr", 64'(mem_addr), 64'(4));
        single(1'b1, 32'h2000_0000, 32'h1234_5678, 4'b1111, 1, 32'h0);
        single(1'b0, 32'h1000_0000, 32'h0, 4'd0, 1, 32'h0);

        for (int i = 0; i < 20; i++) begin
            m = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: a = {7'h40, 25'($urandom)};
                1: a = {7'h10, 25'($urandom)};
                default: begin
                    u = 7'($urandom);
                    if (u == 7'h40 || u == 7'h10) u = 7'h01;
                    a = {u, 25'($urandom)};
                end
            endcase
            ws = $urandom_range(0, 1) ? 4'($urandom) : 4'd0;
            single(m, a, $urandom, ws, $urandom_range(1, 4), $urandom);
        end

        // Contention: M0 psram reads vs M1 flash writes, four each, valids held continuously.
        r0 = 4; r1 = 4; lst = 1'b1;
        while (r0 + r1 > 0) begin
`ifdef QQSPI_ARB_RR_EN
            w = (r0 > 0 && r1 > 0) ? int'(!lst) : (r0 > 0 ? 0 : 1);
`else
            w = r0 > 0 ? 0 : 1;
`endif
            exp_q.push_back(w);
            lst = w[0];
            if (w == 1) r1--; else r0--;
        end
        drive(1'b0, 1'b1, 32'h8000_0100, 32'h0, 4'd0);
        drive(1'b1, 1'b1, 32'h2000_0040, 32'hA5A5_A5A5, 4'b1111);
        n = '{0, 0}; dly = 0; cyc = 0; last_rd = '0;
        while (n[0] + n[1] < 8 && cyc < 400) begin
            for (int k = 0; k < 2; k++) begin
                if (rdy(k[0])) begin
                    got.push_back(k);
                    n[k]++;
                    chk("cont_err", 64'(err(k[0])), 64'(k));
                    if (k == 0) chk("cont_rdata", 64'(m0_rdata), 64'(last_rd));
                    if (n[k] == 4) set_valid(k[0], 1'b0);
                end
            end
            if (mem_ready) mem_ready = 1'b0;
            else if (mem_valid) begin
                if (dly == 0) begin
                    mem_ready = 1'b1;
                    last_rd   = $urandom;
                    mem_rdata = last_rd;
                    dly       = $urandom_range(0, 2);
                end else dly--;
            end
            @(negedge clk);
            cyc++;
        end
        chk("cont_count", 64'(n[0] + n[1]), 64'(8));
        for (int i = 0; i < 8; i++)
            chk("grant_order", 64'(i < got.size() ? got[i] : 9), 64'(exp_q[i]));
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'd0);
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);

        // qqspi still holding ready across reset release.
        mem_ready = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_rd = '{32'd0, 32'd0};
        drive(1'b0, 1'b1, 32'h8000_0040, 32'h0, 4'd0);
        repeat (3) begin
            @(negedge clk);
            chk("hold_no_issue", 64'({mem_valid, m0_ready}), 64'(0));
        end
        mem_ready = 1'b0;
        single(1'b0, 32'h8000_0040, 32'h0, 4'd0, 2, $urandom);

        // Reset in the middle of ISSUE.
        drive(1'b0, 1'b1, 32'h8000_0080, 32'h0, 4'd0);
        @(negedge clk);
        chk("pre_reset_issue", 64'(mem_valid), 64'(1));
        reset = 1'b1;
        #1;
        chk("async_reset", 64'(all_zero()), 64'(1));
        set_valid(1'b0, 1'b0);
        mem_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b0;
        exp_rd = '{32'd0, 32'd0};
        repeat (3) begin
            @(negedge clk);
            chk("no_ready_after_reset", 64'({m0_ready, m1_ready, mem_valid}), 64'(0));
        end
        single(1'b0, 32'h8000_0080, 32'h0, 4'd0, 3, $urandom);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/qqspi_arbiter.md
# qqspi_arbiter

- Two-port arbiter and address decoder in front of the `qqspi` memory controller.
- Shares the single QSPI engine between the CPU data port (M0) and a second requester, such as instruction fetch or DMA (M1).
- Decodes each request to the SPI flash or PSRAM region and drives the controller's per-transaction configuration strobes.
- Enforces the controller's valid/ready release protocol, so that no requester can hang or double-issue a transfer.

## Interface
Parameters:
- `FLASH_BASE`, 32'h2000_0000: flash region base; matched on addr[31:25].
- `PSRAM_BASE`, 32'h8000_0000: PSRAM region base; matched on addr[31:25].
- `FLASH_QUAD`, 1'b0: QUAD_MODE value for flash transactions.
- `PSRAM_QUAD`, 1'b1: QUAD_MODE value for PSRAM transactions.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `m0_valid`, `m1_valid` in 1: request; held until the matching ready pulse.
- `m0_addr`, `m1_addr` in 32: byte address; bits [1:0] ignored.
- `m0_wdata`, `m1_wdata` in 32: write data.
- `m0_wstrb`, `m1_wstrb` in 4: byte strobes; 0 means read.
- `m0_ready`, `m1_ready` out 1: one-cycle completion pulse.
- `m0_rdata`, `m1_rdata` out 32: read data; valid while the matching ready is high.
- `m0_err`, `m1_err` out 1: pulses with ready on an unmapped access or a flash write.
- `mem_valid` out 1; `mem_ready` in 1: to/from `qqspi`.
- `mem_addr` out 23: word address, = addr[24:2].
- `mem_wdata` out 32; `mem_wstrb` out 4; `mem_rdata` in 32.
- `flash_valid`, `psram_valid`, `psram_spiflash`, `quad_mode` out 1: `qqspi` configuration.

## Operation
- State machine: IDLE, ISSUE, DRAIN, RESP.
- IDLE: leaves only when at least one request is pending and `mem_ready`=0.
  - Performs arbitration and decode, and registers all `mem_*` and configuration outputs.
- Decode:
  - PSRAM hit: `psram_valid`=1, `psram_spiflash`=1, `quad_mode`=PSRAM_QUAD, then go to ISSUE.
  - Flash read: `flash_valid`=1, `psram_spiflash`=0, `quad_mode`=FLASH_QUAD, then go to ISSUE.
  - Flash write (wstrb≠0) or no region hit: `qqspi` is not touched; go to RESP with err=1 and rdata=0.
- ISSUE: `mem_valid`=1, with `mem_*` and configuration held constant. On `mem_ready`=1: latch `mem_rdata`, clear `mem_valid`, pulse the grantee's ready, go to DRAIN.
- DRAIN: waits for `mem_ready`=0, then clears flash_valid and psram_valid and goes to IDLE.
- RESP: pulses the grantee's ready and err for one cycle, then goes to IDLE.
- Requester rule: a valid still high in the cycle after its ready pulse is treated as a new request.
- Non-granted master: its ready and err stay 0; its rdata holds its last value.
- Arbitration without the macro: fixed priority, M0 wins.
- Grant is decided only in IDLE and never preempted.
- Outputs toward a master change only on its own ready cycle.

## Timing
- Reset values: every output is 0, rdata registers are 0, state=IDLE, round-robin pointer=M1-last (M0 preferred first).
- Reset takes effect immediately (asynchronous); an in-flight transaction is abandoned and no ready is emitted.
- After reset, IDLE still waits for `mem_ready`=0 before issuing, which covers a `qqspi` reset while it is holding ready.
- Mapped access latency:
  - Request seen in IDLE at cycle 0; `mem_valid` high at cycle 1.
  - `mem_ready` high at cycle N; `mDx_ready` high at cycle N+1 (the "x" being the granted master), together with `mem_valid` falling.
  - Earliest next issue is DRAIN exit + 1.
- Unmapped access or flash write: ready and err at cycle 2.
- Simultaneous requests at cycle 0: the winner is fixed by the arbitration rule; the loser is served after the winner's DRAIN/RESP with no lost request.
- `mem_rdata` is sampled only in the cycle `mem_ready` rises in ISSUE.

## Configuration
- `QQSPI_ARB_RR_EN` defined: round-robin arbitration.
  - When both masters request, the master not granted last wins.
  - The pointer updates on every grant, including error responses.
- Not defined: strict M0 priority; the pointer logic is compiled out.

## Test plan
- M0 read 0x8000_0010, `mem_ready` at cycle 5 with rdata 0xDEADBEEF: `mem_addr`=4, `psram_valid`=1, `psram_spiflash`=1, `quad_mode`=1; m0_ready pulses at cycle 6 with m0_rdata=0xDEADBEEF; m1_ready stays 0.
- M1 write 0x2000_0000 with wstrb 4'b1111: `mem_valid` never rises; m1_ready=1 and m1_err=1 at cycle 2.
- M0 read 0x1000_0000 (unmapped): m0_err=1 and m0_rdata=0 at cycle 2; `qqspi` not touched.
- M0 and M1 requesting simultaneously and continuously for 4 transactions:
  - With RR_EN, grant order is M0,M1,M0,M1.
  - Without RR_EN, M0 completes all 4 before M1 is served.
- Hold `mem_ready`=1 through reset release, then M0 request: no issue until `mem_ready` drops; then a normal transaction.
- Assert reset during ISSUE: all outputs are 0 immediately, no ready pulse; the next request completes normally.
